// File: rtl/morph_pkg.sv
// Shared constants for the 3x3 grey-scale morphology filter: operation/element codes and point masks.
package morph_pkg;

  localparam logic MODE_DILATE = 1'b0;
  localparam logic MODE_ERODE  = 1'b1;
  localparam logic SE_CROSS    = 1'b0;
  localparam logic SE_SQUARE   = 1'b1;

  // Window point index is row*3 + col; col 0 is the newest column, col 1 the centre column.
  localparam logic [8:0] MASK_CROSS  = 9'b010_111_010;
  localparam logic [8:0] MASK_SQUARE = 9'b111_111_111;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/morph_reduce.sv
// Combinational max (dilate) / min (erode) over the masked points of a 3x3 window.
// Zero latency; no flow control.
module morph_reduce
  import morph_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [8:0][DATA_W-1:0] pix_i,
  input  logic [8:0]             mask_i,
  input  logic                   mode_i,
  output logic [DATA_W-1:0]      res_o
);

  always_comb begin
    // Start from the identity of the chosen operation so masked-out points cannot win.
    res_o = (mode_i == MODE_ERODE) ? '1 : '0;
    for (int i = 0; i < 9; i++) begin
      if (mask_i[i]) begin
        if (mode_i == MODE_ERODE) begin
          if (pix_i[i] < res_o) res_o = pix_i[i];
        end else begin
          if (pix_i[i] > res_o) res_o = pix_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_morph.sv
// 3x3 morphological dilate/erode over a column stream; 2-clock latency from accepting edge to valid_out.
// No backpressure: valid_in stalls hold the window and column count, the pipeline always advances.
module matrix_morph
  import morph_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PIC_WIDTH = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              mode,
  input  logic              se_sel,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout,
  output logic              eol_out
);

  localparam int               CNT_W    = cnt_width(PIC_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);
  localparam logic [CNT_W-1:0] FIRST_OUT_COL = CNT_W'(2);

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [2:0][2:0][DATA_W-1:0]   win_q, win_d;
  logic                          mode_q, mode_d;
  logic                          se_q, se_d;
  logic                          wvld_q, wvld_d;
  logic                          weol_q, weol_d;
  logic [DATA_W-1:0]             res_q, res_d;
  logic                          rvld_q, rvld_d;
  logic                          reol_q, reol_d;
  logic [DATA_W-1:0]             dout_q, dout_d;
  logic                          vout_q, vout_d;
  logic                          eol_q, eol_d;

  logic [8:0][DATA_W-1:0]        pix_flat;
  logic [8:0]                    mask;
  logic [DATA_W-1:0]             red_res;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pix_flat[r*3 + c] = win_q[r][c];
      end
    end
    mask = (se_q == SE_SQUARE) ? MASK_SQUARE : MASK_CROSS;
  end

  morph_reduce #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .pix_i  (pix_flat),
    .mask_i (mask),
    .mode_i (mode_q),
    .res_o  (red_res)
  );

  // Stage 0: column acceptance, window shift and per-line control latch.
  always_comb begin
    cnt_d  = cnt_q;
    win_d  = win_q;
    mode_d = mode_q;
    se_d   = se_q;
    wvld_d = 1'b0;
    weol_d = 1'b0;
    if (valid_in) begin
      cnt_d = (cnt_q == LAST_COL) ? '0 : cnt_q + CNT_W'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[r][2] = win_q[r][1];
        win_d[r][1] = win_q[r][0];
      end
      win_d[0][0] = din1;
      win_d[1][0] = din2;
      win_d[2][0] = din3;
      if (cnt_q == '0) begin
        mode_d = mode;
        se_d   = se_sel;
      end
      wvld_d = (cnt_q >= FIRST_OUT_COL);
      weol_d = (cnt_q == LAST_COL);
    end
  end

  // Stages 1 and 2: register the reduction, then present it; dout holds between results.
  always_comb begin
    res_d  = rvld_q ? res_q : res_q;
    if (wvld_q) res_d = red_res;
    rvld_d = wvld_q;
    reol_d = wvld_q & weol_q;
    dout_d = rvld_q ? res_q : dout_q;
    vout_d = rvld_q;
    eol_d  = rvld_q & reol_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      win_q  <= '0;
      mode_q <= MODE_DILATE;
      se_q   <= SE_CROSS;
      wvld_q <= 1'b0;
      weol_q <= 1'b0;
      res_q  <= '0;
      rvld_q <= 1'b0;
      reol_q <= 1'b0;
      dout_q <= '0;
      vout_q <= 1'b0;
      eol_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      mode_q <= mode_d;
      se_q   <= se_d;
      wvld_q <= wvld_d;
      weol_q <= weol_d;
      res_q  <= res_d;
      rvld_q <= rvld_d;
      reol_q <= reol_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      eol_q  <= eol_d;
    end
  end

  assign valid_out = vout_q;
  assign dout      = dout_q;
  assign eol_out   = eol_q;

endmodule
